// File: rtl/mem_pkg.sv
// Shared types and helpers for the c2c memory-side arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        CH_INSTR = 2'd0,
        CH_DR    = 2'd1,
        CH_DW    = 2'd2
    } chan_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Byte address to word address; the caller truncates to the memory width.
    function automatic logic [63:0] byte_to_word(input logic [63:0] addr,
                                                 input int unsigned xlen);
        return (xlen == 64) ? (addr >> 3) : (addr >> 2);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module rr_arb3
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req_i,
    input  chan_e      last_i,
    input  logic       advance_i,
    output logic [2:0] gnt_o
);

    chan_e ptr_q;

    // Pointer holds the last granted channel; CH_DR at reset makes dw the first choice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= CH_DR;
        end else if (advance_i) begin
            ptr_q <= last_i;
        end
    end

    always_comb begin
        gnt_o = 3'b000;
        case (ptr_q)
            CH_INSTR: gnt_o = req_i[1] ? 3'b010 : req_i[2] ? 3'b100 : req_i[0] ? 3'b001 : 3'b000;
            CH_DR:    gnt_o = req_i[2] ? 3'b100 : req_i[0] ? 3'b001 : req_i[1] ? 3'b010 : 3'b000;
            default:  gnt_o = req_i[0] ? 3'b001 : req_i[1] ? 3'b010 : req_i[2] ? 3'b100 : 3'b000;
        endcase
    end

endmodule

// File: rtl/c2c_mem_arbiter.sv
// Merges the instruction-read, data-read and data-write c2c channels onto one
// single-ported synchronous memory, one transaction at a time.
module c2c_mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_re,
    input  logic [XLEN/8-1:0]   instr_sel,
    input  logic [XLEN-1:0]     instr_addr,
    output logic                instr_ack,
    output logic [31:0]         instr_data,
    input  logic                dr_re,
    input  logic [XLEN/8-1:0]   dr_sel,
    input  logic [XLEN-1:0]     dr_addr,
    output logic                dr_ack,
    output logic [XLEN-1:0]     dr_data,
    input  logic                dw_we,
    input  logic [XLEN/8-1:0]   dw_sel,
    input  logic [XLEN-1:0]     dw_addr,
    input  logic [XLEN-1:0]     dw_data,
    output logic                dw_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned SelW = XLEN / 8;

    state_e            state_q, state_d;
    chan_e             chan_q, chan_d;
    logic              hi_half_q, hi_half_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        hold_q, hold_d;
    logic [2:0]        ack_q, ack_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [SelW-1:0]   mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]       instr_data_q, instr_data_d;
    logic [XLEN-1:0]   dr_data_q, dr_data_d;

    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [XLEN-1:0]   gnt_addr;
    logic [31:0]       fetch_word;
    logic              unused_in;

    // A channel just acked still shows its request for one cycle; mask it.
    assign req = {dw_we, dr_re, instr_re} & ~hold_q;

    rr_arb3 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req),
        .last_i    (chan_q),
        .advance_i (state_q == RESP),
        .gnt_o     (gnt)
    );

    if (XLEN == 64) begin : g_fetch64
        assign fetch_word = hi_half_q ? mem_rdata[XLEN-1:32] : mem_rdata[31:0];
    end else begin : g_fetch32
        assign fetch_word = mem_rdata[31:0];
    end

    assign unused_in = ^{instr_sel, dr_sel, hi_half_q};

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        hi_half_d    = hi_half_q;
        cnt_d        = cnt_q;
        hold_d       = 3'b000;
        ack_d        = 3'b000;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        instr_data_d = instr_data_q;
        dr_data_d    = dr_data_q;
        gnt_addr     = '0;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    mem_be_d = '1;
                    unique case (1'b1)
                        gnt[CH_INSTR]: begin
                            chan_d   = CH_INSTR;
                            gnt_addr = instr_addr;
                        end
                        gnt[CH_DR]: begin
                            chan_d   = CH_DR;
                            gnt_addr = dr_addr;
                        end
                        gnt[CH_DW]: begin
                            chan_d      = CH_DW;
                            gnt_addr    = dw_addr;
                            mem_we_d    = 1'b1;
                            mem_be_d    = dw_sel;
                            mem_wdata_d = dw_data;
                        end
                    endcase
                    mem_req_d  = 1'b1;
                    mem_addr_d = ADDR_W'(byte_to_word(64'(gnt_addr), XLEN));
                    hi_half_d  = gnt_addr[2];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (chan_q == CH_DW) begin
                    ack_d[chan_q] = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d   = 3'(MEM_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_d == 3'd0) begin
                    ack_d[chan_q] = 1'b1;
                    state_d       = RESP;
                    if (chan_q == CH_INSTR) begin
                        instr_data_d = fetch_word;
                    end else begin
                        dr_data_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                hold_d[chan_q] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            chan_q       <= CH_INSTR;
            hi_half_q    <= 1'b0;
            cnt_q        <= 3'd0;
            hold_q       <= 3'b000;
            ack_q        <= 3'b000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            instr_data_q <= '0;
            dr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            hi_half_q    <= hi_half_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            ack_q        <= ack_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_data_q <= instr_data_d;
            dr_data_q    <= dr_data_d;
        end
    end

    assign instr_ack  = ack_q[CH_INSTR];
    assign dr_ack     = ack_q[CH_DR];
    assign dw_ack     = ack_q[CH_DW];
    assign instr_data = instr_data_q;
    assign dr_data    = dr_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_c2c_mem_arbiter.sv
// Scoreboard bench for c2c_mem_arbiter: expected memory accesses and acks are
// queued by the stimulus and consumed by a negedge monitor.
module tb_c2c_mem_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        ram_clr;
    logic        instr_re, dr_re, dw_we;
    logic [3:0]  instr_sel, dr_sel, dw_sel;
    logic [31:0] instr_addr, dr_addr, dw_addr, dw_data;
    logic        instr_ack, dr_ack, dw_ack;
    logic [31:0] instr_data, dr_data;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    logic        instr_re64;
    logic [63:0] instr_addr64;
    logic        instr_ack64;
    logic [31:0] instr_data64;
    logic        mem_req64;
    logic [13:0] mem_addr64;
    logic [7:0]  mem_be64;
    logic [63:0] mem_rdata64;
    logic        dr_ack64_unused, dw_ack64_unused, mem_we64_unused;
    logic [63:0] dr_data64_unused, mem_wdata64_unused;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        chan_e       ch;
        logic [31:0] data;
        bit          chk;
    } ack_t;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mtx_t;

    ack_t ack_q[$];
    mtx_t mem_q[$];
    logic [31:0] ram [0:255];

    c2c_mem_arbiter #(.XLEN(32), .ADDR_W(14), .MEM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr), .dr_ack(dr_ack), .dr_data(dr_data),
        .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data), .dw_ack(dw_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    c2c_mem_arbiter #(.XLEN(64), .ADDR_W(14), .MEM_LATENCY(1)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .instr_re(instr_re64), .instr_sel(8'hFF), .instr_addr(instr_addr64),
        .instr_ack(instr_ack64), .instr_data(instr_data64),
        .dr_re(1'b0), .dr_sel(8'h00), .dr_addr(64'd0), .dr_ack(dr_ack64_unused),
        .dr_data(dr_data64_unused),
        .dw_we(1'b0), .dw_sel(8'h00), .dw_addr(64'd0), .dw_data(64'd0), .dw_ack(dw_ack64_unused),
        .mem_req(mem_req64), .mem_we(mem_we64_unused), .mem_addr(mem_addr64), .mem_be(mem_be64),
        .mem_wdata(mem_wdata64_unused), .mem_rdata(mem_rdata64)
    );

    // Synchronous RAM, one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8'h40] <= 32'h0000_0013;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin : monitor
        ack_t        ea;
        mtx_t        em;
        chan_e       ch;
        logic [31:0] d;
        if (reset_n && (instr_ack || dr_ack || dw_ack)) begin
            check("single_ack", 64'($countones({instr_ack, dr_ack, dw_ack})), 64'd1);
            ch = instr_ack ? CH_INSTR : (dr_ack ? CH_DR : CH_DW);
            d  = instr_ack ? instr_data : (dr_ack ? dr_data : 32'h0);
            if (ack_q.size() == 0) begin
                fail_now($sformatf("unexpected_ack ch=%0d", ch));
            end else begin
                ea = ack_q.pop_front();
                check("ack_chan", 64'(ch), 64'(ea.ch));
                if (ea.chk) check("ack_data", 64'(d), 64'(ea.data));
            end
        end
        if (reset_n && mem_req) begin
            if (mem_q.size() == 0) begin
                fail_now($sformatf("unexpected_mem_req addr=0x%0h", mem_addr));
            end else begin
                em = mem_q.pop_front();
                check("mem_we", 64'(mem_we), 64'(em.we));
                check("mem_addr", 64'(mem_addr), 64'(em.addr));
                check("mem_be", 64'(mem_be), 64'(em.be));
                if (em.we) check("mem_wdata", 64'(mem_wdata), 64'(em.wdata));
            end
        end
    end

    // exp_lat < 0 skips latency checks (used under contention).
    task automatic do_xfer(input chan_e ch, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input int exp_lat, input bit drop);
        int   n = 0;
        int   req_n;
        logic got;
        req_n = exp_lat - ((ch == CH_DW) ? 1 : 2);
        case (ch)
            CH_INSTR: begin instr_re = 1'b1; instr_addr = addr; instr_sel = sel; end
            CH_DR:    begin dr_re = 1'b1; dr_addr = addr; dr_sel = sel; end
            default:  begin dw_we = 1'b1; dw_addr = addr; dw_sel = sel; dw_data = data; end
        endcase
        do begin
            @(posedge clk);
            #1;
            n++;
            if (exp_lat > 0 && n == req_n) check("mem_req_timing", 64'(mem_req), 64'd1);
            got = (ch == CH_INSTR) ? instr_ack : ((ch == CH_DR) ? dr_ack : dw_ack);
        end while (!got && n < 40);
        if (!got) fail_now($sformatf("ack_timeout ch=%0d", ch));
        else if (exp_lat > 0) check("ack_latency", 64'(n), 64'(exp_lat));
        @(posedge clk);
        #1;
        if (drop) begin
            @(posedge clk);
            #1;
            case (ch)
                CH_INSTR: instr_re = 1'b0;
                CH_DR:    dr_re = 1'b0;
                default:  dw_we = 1'b0;
            endcase
        end
    endtask

    task automatic xfer64(input logic [63:0] a, input logic [31:0] exp_d);
        int n = 0;
        instr_re64   = 1'b1;
        instr_addr64 = a;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (mem_req64) begin
                check("m64_addr", 64'(mem_addr64), 64'h20);
                check("m64_be", 64'(mem_be64), 64'hFF);
            end
        end while (!instr_ack64 && n < 20);
        if (!instr_ack64) begin
            fail_now("ack64_timeout");
        end else begin
            check("i64_latency", 64'(n), 64'd3);
            check("i64_data", 64'(instr_data64), 64'(exp_d));
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        instr_re64 = 1'b0;
    endtask

    task automatic push_rd(input chan_e ch, input logic [13:0] wa, input logic [31:0] d);
        mem_q.push_back('{we: 1'b0, addr: wa, be: 4'hF, wdata: 32'h0});
        ack_q.push_back('{ch: ch, data: d, chk: 1'b1});
    endtask

    task automatic push_wr(input logic [13:0] wa, input logic [3:0] be, input logic [31:0] d);
        mem_q.push_back('{we: 1'b1, addr: wa, be: be, wdata: d});
        ack_q.push_back('{ch: CH_DW, data: 32'h0, chk: 1'b0});
    endtask

    initial begin
        reset_n = 1'b0;
        ram_clr = 1'b1;
        {instr_re, dr_re, dw_we} = 3'b000;
        {instr_sel, dr_sel, dw_sel} = '0;
        {instr_addr, dr_addr, dw_addr, dw_data} = '0;
        instr_re64   = 1'b0;
        instr_addr64 = '0;
        mem_rdata64  = 64'h1111_1111_2222_2222;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_ack", 64'(instr_ack), 64'd0);
        check("rst_dr_ack", 64'(dr_ack), 64'd0);
        check("rst_dw_ack", 64'(dw_ack), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_instr_data", 64'(instr_data), 64'd0);
        check("rst_dr_data", 64'(dr_data), 64'd0);
        ram_clr = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch, then holdoff: no re-grant while the stale request is masked.
        push_rd(CH_INSTR, 14'h40, 32'h0000_0013);
        do_xfer(CH_INSTR, 32'h100, 4'hF, 32'h0, 3, 1'b1);
        check("holdoff_no_regrant", 64'(mem_req), 64'd0);

        // Byte write then full-word read back.
        push_wr(14'h2, 4'b0010, 32'hAABB_CCDD);
        do_xfer(CH_DW, 32'h8, 4'b0010, 32'hAABB_CCDD, 2, 1'b1);
        push_rd(CH_DR, 14'h2, 32'h0000_CC00);
        do_xfer(CH_DR, 32'h8, 4'b0001, 32'h0, 3, 1'b1);

        // Request kept high through holdoff is re-granted one cycle later.
        push_rd(CH_INSTR, 14'h40, 32'h0000_0013);
        push_rd(CH_INSTR, 14'h40, 32'h0000_0013);
        do_xfer(CH_INSTR, 32'h100, 4'hF, 32'h0, 3, 1'b0);
        do_xfer(CH_INSTR, 32'h100, 4'hF, 32'h0, 4, 1'b1);

        // Reset in the middle of a read wait.
        mem_q.push_back('{we: 1'b0, addr: 14'h2, be: 4'hF, wdata: 32'h0});
        dr_re   = 1'b1;
        dr_addr = 32'h8;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        dr_re   = 1'b0;
        #1;
        check("midrst_dr_ack", 64'(dr_ack), 64'd0);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        check("midrst_instr_data", 64'(instr_data), 64'd0);
        check("midrst_dr_data", 64'(dr_data), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // All three contend twice: dw first after reset, then rotation instr, dr, dw.
        repeat (2) begin
            push_wr(14'h4, 4'hF, 32'h1234_5678);
            push_rd(CH_INSTR, 14'h40, 32'h0000_0013);
            push_rd(CH_DR, 14'h2, 32'h0000_CC00);
        end
        fork
            begin
                do_xfer(CH_DW, 32'h10, 4'hF, 32'h1234_5678, -1, 1'b0);
                do_xfer(CH_DW, 32'h10, 4'hF, 32'h1234_5678, -1, 1'b1);
            end
            begin
                do_xfer(CH_INSTR, 32'h100, 4'hF, 32'h0, -1, 1'b0);
                do_xfer(CH_INSTR, 32'h100, 4'hF, 32'h0, -1, 1'b1);
            end
            begin
                do_xfer(CH_DR, 32'h8, 4'hF, 32'h0, -1, 1'b0);
                do_xfer(CH_DR, 32'h8, 4'hF, 32'h0, -1, 1'b1);
            end
        join

        // 64-bit instance: addr[2] picks the instruction half.
        xfer64(64'h104, 32'h1111_1111);
        xfer64(64'h100, 32'h2222_2222);

        repeat (4) @(posedge clk);
        #1;
        check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
